// File: rtl/magia_fsync_root.sv
// magia_fsync_root: FractalSync root node for the MAGIA mesh.
// Tracks per-id H/V pending state, completes a barrier when both links have
// requested the same id, and emits one wake per cycle, lowest id first.
// Optional half-pending timeout: define MAGIA_FSYNC_ROOT_TMO_EN.
module magia_fsync_root #(
  parameter int unsigned LVL_W    = 2,
  parameter int unsigned ID_W     = 2,
  parameter int unsigned ROOT_LVL = 2,
  parameter int unsigned TMO_CYC  = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   h_sync_i,
  input  logic [LVL_W-1:0]       h_lvl_i,
  input  logic [ID_W-1:0]        h_id_i,
  input  logic                   v_sync_i,
  input  logic [LVL_W-1:0]       v_lvl_i,
  input  logic [ID_W-1:0]        v_id_i,
  output logic                   wake_o,
  output logic [LVL_W-1:0]       wake_lvl_o,
  output logic [ID_W-1:0]        wake_id_o,
  output logic                   h_err_o,
  output logic [ID_W-1:0]        h_err_id_o,
  output logic                   v_err_o,
  output logic [ID_W-1:0]        v_err_id_o,
  output logic [2*(2**ID_W)-1:0] pending_o,
  output logic [15:0]            done_cnt_o
);

  localparam int unsigned     NIds    = 2**ID_W;
  localparam logic [LVL_W-1:0] RootLvl = LVL_W'(ROOT_LVL);

  logic [NIds-1:0] h_pend_q, h_pend_d;
  logic [NIds-1:0] v_pend_q, v_pend_d;
  logic [NIds-1:0] done_q, done_d;
  logic            wake_q, wake_d;
  logic [ID_W-1:0] wake_id_q, wake_id_d;
  logic            h_err_q, h_err_d;
  logic [ID_W-1:0] h_err_id_q, h_err_id_d;
  logic            v_err_q, v_err_d;
  logic [ID_W-1:0] v_err_id_q, v_err_id_d;
  logic [15:0]     done_cnt_q, done_cnt_d;

  // Timeout service for the current cycle (constant zero when the feature is off).
  logic            tmo_fire;
  logic            tmo_on_h;
  logic [ID_W-1:0] tmo_id;
  logic [NIds-1:0] tmo_clr_h, tmo_clr_v;

`ifdef MAGIA_FSYNC_ROOT_TMO_EN
  localparam int unsigned CntW = $clog2(TMO_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TMO_CYC - 1);

  logic [CntW-1:0] tmo_cnt_q [NIds];
  logic [CntW-1:0] tmo_cnt_d [NIds];
  logic [NIds-1:0] half, expired;

  // Pick the lowest expired half-pending id; later ones hold at terminal count.
  always_comb begin
    half      = h_pend_q ^ v_pend_q;
    expired   = '0;
    tmo_fire  = 1'b0;
    tmo_id    = '0;
    tmo_on_h  = 1'b0;
    tmo_clr_h = '0;
    tmo_clr_v = '0;
    for (int k = 0; k < NIds; k++) begin
      expired[k] = half[k] && (tmo_cnt_q[k] >= CntLast);
    end
    for (int k = NIds - 1; k >= 0; k--) begin
      if (expired[k]) begin
        tmo_fire = 1'b1;
        tmo_id   = ID_W'(k);
      end
    end
    if (tmo_fire) begin
      tmo_on_h = h_pend_q[tmo_id];
      if (tmo_on_h) tmo_clr_h[tmo_id] = 1'b1;
      else          tmo_clr_v[tmo_id] = 1'b1;
    end
    for (int k = 0; k < NIds; k++) begin
      tmo_cnt_d[k] = tmo_cnt_q[k];
      if (!half[k] || (tmo_fire && (tmo_id == ID_W'(k)))) tmo_cnt_d[k] = '0;
      else if (!expired[k])                               tmo_cnt_d[k] = tmo_cnt_q[k] + 1'b1;
    end
  end

  // Per-id half-pending counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NIds; k++) tmo_cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NIds; k++) tmo_cnt_q[k] <= tmo_cnt_d[k];
    end
  end
`else
  assign tmo_fire  = 1'b0;
  assign tmo_on_h  = 1'b0;
  assign tmo_id    = '0;
  assign tmo_clr_h = '0;
  assign tmo_clr_v = '0;
`endif

  logic            h_ok, v_ok;
  logic [NIds-1:0] h_set, v_set, h_nxt, v_nxt, cmpl;

  // Request acceptance, completion, wake scan and error reporting.
  always_comb begin
    h_ok  = h_sync_i && (h_lvl_i == RootLvl) && !h_pend_q[h_id_i] && !done_q[h_id_i];
    v_ok  = v_sync_i && (v_lvl_i == RootLvl) && !v_pend_q[v_id_i] && !done_q[v_id_i];
    h_set = '0;
    v_set = '0;
    if (h_ok) h_set[h_id_i] = 1'b1;
    if (v_ok) v_set[v_id_i] = 1'b1;

    // A timed-out bit is gone before this cycle's requests are merged in.
    h_nxt    = (h_pend_q & ~tmo_clr_h) | h_set;
    v_nxt    = (v_pend_q & ~tmo_clr_v) | v_set;
    cmpl     = h_nxt & v_nxt;
    h_pend_d = h_nxt & ~cmpl;
    v_pend_d = v_nxt & ~cmpl;

    wake_d    = 1'b0;
    wake_id_d = '0;
    for (int k = NIds - 1; k >= 0; k--) begin
      if (done_q[k]) begin
        wake_d    = 1'b1;
        wake_id_d = ID_W'(k);
      end
    end
    done_d = done_q;
    if (wake_d) done_d[wake_id_d] = 1'b0;
    done_d = done_d | cmpl;

    // Two different ids can complete in the same cycle.
    done_cnt_d = done_cnt_q;
    for (int k = 0; k < NIds; k++) begin
      if (cmpl[k]) done_cnt_d = done_cnt_d + 16'd1;
    end

    h_err_d    = h_sync_i && !h_ok;
    h_err_id_d = h_err_d ? h_id_i : '0;
    v_err_d    = v_sync_i && !v_ok;
    v_err_id_d = v_err_d ? v_id_i : '0;
    // A timeout owns its link's error port; a coinciding request error is dropped.
    if (tmo_fire && tmo_on_h) begin
      h_err_d    = 1'b1;
      h_err_id_d = tmo_id;
    end
    if (tmo_fire && !tmo_on_h) begin
      v_err_d    = 1'b1;
      v_err_id_d = tmo_id;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_pend_q   <= '0;
      v_pend_q   <= '0;
      done_q     <= '0;
      wake_q     <= 1'b0;
      wake_id_q  <= '0;
      h_err_q    <= 1'b0;
      h_err_id_q <= '0;
      v_err_q    <= 1'b0;
      v_err_id_q <= '0;
      done_cnt_q <= '0;
    end else begin
      h_pend_q   <= h_pend_d;
      v_pend_q   <= v_pend_d;
      done_q     <= done_d;
      wake_q     <= wake_d;
      wake_id_q  <= wake_id_d;
      h_err_q    <= h_err_d;
      h_err_id_q <= h_err_id_d;
      v_err_q    <= v_err_d;
      v_err_id_q <= v_err_id_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign wake_o     = wake_q;
  assign wake_id_o  = wake_id_q;
  assign wake_lvl_o = wake_q ? RootLvl : '0;
  assign h_err_o    = h_err_q;
  assign h_err_id_o = h_err_id_q;
  assign v_err_o    = v_err_q;
  assign v_err_id_o = v_err_id_q;
  assign pending_o  = {v_pend_q, h_pend_q};
  assign done_cnt_o = done_cnt_q;

endmodule
